if_id_stage: RTL and testbench

Pipeline boundary between the fetch stage and instruction decode. Captures the fetched instruction and its incremented PC into an IF/ID latch with stall, flush and halt handling. Holds the 8×16 architectural register file, which is read through the latched instruction's source fields with same-cycle write-back bypass. Raises the sticky halt signal that freezes the fetch PC.

---
 rtl/if_id_stage_pkg.sv | 36 +++
 rtl/if_id_stage_if.sv | 36 +++
 rtl/if_id_stage_rf_bypass.sv | 45 ++++
 rtl/if_id_stage.sv | 73 +++++++
 tb/tb_if_id_stage.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/if_id_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_id_stage_pkg
// Shared definitions for the IF/ID pipeline boundary: 16-bit ISA field
// positions, the NOP and HALT encodings, register-file geometry and the
// IF/ID latch record.
// -----------------------------------------------------------------------------
package if_id_stage_pkg;

    localparam int XLEN     = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = 3;

    localparam logic [XLEN-1:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]      OP_HALT   = 5'b00000;

    // Contents of the IF/ID latch.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] next_pc;
        logic            valid;
    } ifid_latch_t;

    // Instruction field extraction: OPCODE [15:11], RS [10:8], RT [7:5].
    function automatic logic [4:0] opcode_f(input logic [XLEN-1:0] instr);
        return instr[15:11];
    endfunction

    function automatic logic [REG_AW-1:0] rs_f(input logic [XLEN-1:0] instr);
        return instr[10:8];
    endfunction

    function automatic logic [REG_AW-1:0] rt_f(input logic [XLEN-1:0] instr);
        return instr[7:5];
    endfunction

endpackage : if_id_stage_pkg

// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Signal bundle between the fetch/write-back side (master) and the IF/ID
// stage (slave).
//   master drives : stall, flush, instrIn, nextPcIn, wbEn, wbReg, wbData
//   slave  drives : instrOut, nextPcOut, validOut, rsData, rtData, haltOut
// -----------------------------------------------------------------------------
interface if_id_stage_if;
    import if_id_stage_pkg::*;

    logic              stall;
    logic              flush;
    logic [XLEN-1:0]   instrIn;
    logic [XLEN-1:0]   nextPcIn;
    logic              wbEn;
    logic [REG_AW-1:0] wbReg;
    logic [XLEN-1:0]   wbData;

    logic [XLEN-1:0]   instrOut;
    logic [XLEN-1:0]   nextPcOut;
    logic              validOut;
    logic [XLEN-1:0]   rsData;
    logic [XLEN-1:0]   rtData;
    logic              haltOut;

    modport master (
        output stall, flush, instrIn, nextPcIn, wbEn, wbReg, wbData,
        input  instrOut, nextPcOut, validOut, rsData, rtData, haltOut
    );

    modport slave (
        input  stall, flush, instrIn, nextPcIn, wbEn, wbReg, wbData,
        output instrOut, nextPcOut, validOut, rsData, rtData, haltOut
    );

endinterface : if_id_stage_if

// File: rtl/if_id_stage_rf_bypass.sv
// -----------------------------------------------------------------------------
// rf_bypass
// 8x16 register file: one synchronous write port, two combinational read
// ports with write-first bypass, synchronous clear on rst.
//   clk, rst     : clock, synchronous active-high clear
//   we_i         : write enable
//   waddr_i      : write index
//   wdata_i      : write data
//   raddr_a/b_i  : read indices
//   rdata_a/b_o  : read data (bypassed from wdata_i on index match)
// -----------------------------------------------------------------------------
module rf_bypass
    import if_id_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [XLEN-1:0]   rdata_a_o,
    output logic [XLEN-1:0]   rdata_b_o
);

    logic [XLEN-1:0] regs_q [NUM_REGS];

    // NOTE: this storage is reset explicitly because the ISA defines every
    // register as reading 0 after reset; an 8-entry flop array costs little,
    // unlike a RAM macro which could not be cleared in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Write-first: a value being written this cycle is visible immediately.
    assign rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : regs_q[raddr_a_i];
    assign rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : regs_q[raddr_b_i];

endmodule : rf_bypass

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline boundary: latches the fetched instruction and PC+2 with
// flush/stall/halt control, raises the sticky halt flag, and hosts the
// architectural register file read through the latched RS/RT fields.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of if_id_stage_if (fetch, write-back, decode outputs)
// -----------------------------------------------------------------------------
module if_id_stage
    import if_id_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    if_id_stage_if.slave bus
);

    ifid_latch_t latch_q, latch_d;
    logic        halt_q, halt_d;
    logic        halt_seen;

    // A valid HALT on the latch freezes it in the same edge that raises
    // haltOut, so the single instruction fetched behind the HALT is dropped.
    always_comb begin
        halt_seen = latch_q.valid && (opcode_f(latch_q.instr) == OP_HALT);
        halt_d    = halt_q || halt_seen;

        // NOTE: default assignment first so every path assigns latch_d and
        // no latch is inferred in this combinational block.
        latch_d = latch_q;
        if (bus.flush) begin
            latch_d.instr   = NOP_INSTR;
            latch_d.next_pc = bus.nextPcIn;
            latch_d.valid   = 1'b0;
        end else if (!(halt_d || bus.stall)) begin
            latch_d.instr   = bus.instrIn;
            latch_d.next_pc = bus.nextPcIn;
            latch_d.valid   = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            latch_q.instr   <= NOP_INSTR;
            latch_q.next_pc <= '0;
            latch_q.valid   <= 1'b0;
            halt_q          <= 1'b0;
        end else begin
            latch_q <= latch_d;
            halt_q  <= halt_d;
        end
    end

    assign bus.instrOut  = latch_q.instr;
    assign bus.nextPcOut = latch_q.next_pc;
    assign bus.validOut  = latch_q.valid;
    assign bus.haltOut   = halt_q;

    // Reads are not gated by validOut: a bubble reads what its NOP fields select.
    rf_bypass u_rf (
        .clk       (clk),
        .rst       (rst),
        .we_i      (bus.wbEn),
        .waddr_i   (bus.wbReg),
        .wdata_i   (bus.wbData),
        .raddr_a_i (rs_f(latch_q.instr)),
        .raddr_b_i (rt_f(latch_q.instr)),
        .rdata_a_o (bus.rsData),
        .rdata_b_o (bus.rtData)
    );

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Directed self-checking bench for if_id_stage. Inputs are driven 1 ns after
// the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;

    if_id_stage_if bus ();

    if_id_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.instrIn  = 16'h0000;
        bus.nextPcIn = 16'h0000;
        bus.wbEn     = 1'b0;
        bus.wbReg    = 3'd0;
        bus.wbData   = 16'h0000;

        // ---- reset ----
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_instr", bus.instrOut, 16'h0800);
        check("rst_npc",   bus.nextPcOut, 16'h0000);
        check("rst_valid", {15'd0, bus.validOut}, 16'h0000);
        check("rst_halt",  {15'd0, bus.haltOut}, 16'h0000);
        check("rst_rs",    bus.rsData, 16'h0000);

        // ---- plain capture ----
        bus.instrIn  = 16'hC123;
        bus.nextPcIn = 16'h0002;
        step();
        check("cap_instr", bus.instrOut, 16'hC123);
        check("cap_npc",   bus.nextPcOut, 16'h0002);
        check("cap_valid", {15'd0, bus.validOut}, 16'h0001);

        // ---- stall holds for 3 cycles while input changes ----
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.instrIn  = 16'hC200 + 16'(i);
            bus.nextPcIn = 16'h0004 + 16'(2 * i);
            step();
            check("stall_instr", bus.instrOut, 16'hC123);
            check("stall_npc",   bus.nextPcOut, 16'h0002);
        end

        // ---- flush beats stall ----
        bus.flush    = 1'b1;
        bus.nextPcIn = 16'h0010;
        step();
        check("flush_instr", bus.instrOut, 16'h0800);
        check("flush_valid", {15'd0, bus.validOut}, 16'h0000);
        check("flush_npc",   bus.nextPcOut, 16'h0010);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // ---- register file bypass: rs=3, rt=3 ----
        bus.instrIn  = 16'h0B60;
        bus.nextPcIn = 16'h0012;
        step();
        check("rf_instr", bus.instrOut, 16'h0B60);
        check("rf_rs_pre", bus.rsData, 16'h0000);
        bus.wbEn   = 1'b1;
        bus.wbReg  = 3'd3;
        bus.wbData = 16'hBEEF;
        #1;
        check("byp_rs", bus.rsData, 16'hBEEF);
        check("byp_rt", bus.rtData, 16'hBEEF);
        step();
        bus.wbEn = 1'b0;
        #1;
        check("store_rs", bus.rsData, 16'hBEEF);
        check("store_rt", bus.rtData, 16'hBEEF);
        // Write to a non-matching index must not disturb the reads.
        bus.wbEn   = 1'b1;
        bus.wbReg  = 3'd5;
        bus.wbData = 16'h1234;
        #1;
        check("nobyp_rs", bus.rsData, 16'hBEEF);
        step();
        bus.wbEn = 1'b0;

        // ---- read r3 and r5 together (rs=3, rt=5) ----
        bus.instrIn  = 16'h0BA0;
        bus.nextPcIn = 16'h0014;
        step();
        check("r3_rs", bus.rsData, 16'hBEEF);
        check("r5_rt", bus.rtData, 16'h1234);

        // ---- HALT ----
        bus.instrIn  = 16'h0000;
        bus.nextPcIn = 16'h0020;
        step();
        check("halt_lat_instr", bus.instrOut, 16'h0000);
        check("halt_lat_valid", {15'd0, bus.validOut}, 16'h0001);
        check("halt_lat_flag",  {15'd0, bus.haltOut}, 16'h0000);
        bus.instrIn  = 16'h4000;
        bus.nextPcIn = 16'h0022;
        step();
        check("halt_flag",   {15'd0, bus.haltOut}, 16'h0001);
        check("halt_frozen", bus.instrOut, 16'h0000);
        check("halt_npc",    bus.nextPcOut, 16'h0020);
        for (int i = 0; i < 10; i++) begin
            bus.stall   = i[0];
            bus.instrIn = 16'h4000 + 16'(i);
            step();
            check("halt_sticky", {15'd0, bus.haltOut}, 16'h0001);
            check("halt_hold",   bus.instrOut, 16'h0000);
        end
        bus.stall = 1'b0;

        // ---- flush while halted ----
        bus.flush    = 1'b1;
        bus.nextPcIn = 16'h0030;
        step();
        bus.flush = 1'b0;
        check("hflush_valid", {15'd0, bus.validOut}, 16'h0000);
        check("hflush_halt",  {15'd0, bus.haltOut}, 16'h0001);
        check("hflush_instr", bus.instrOut, 16'h0800);

        // ---- reset while halted ----
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rrst_halt",  {15'd0, bus.haltOut}, 16'h0000);
        check("rrst_instr", bus.instrOut, 16'h0800);
        check("rrst_valid", {15'd0, bus.validOut}, 16'h0000);
        bus.instrIn  = 16'h0BA0;
        bus.nextPcIn = 16'h0042;
        step();
        check("rrst_cap",   bus.instrOut, 16'h0BA0);
        check("rrst_npc",   bus.nextPcOut, 16'h0042);
        check("rrst_r3",    bus.rsData, 16'h0000);
        check("rrst_r5",    bus.rtData, 16'h0000);

        // ---- flushed HALT does not halt ----
        bus.instrIn  = 16'h0000;
        bus.nextPcIn = 16'h0044;
        bus.flush    = 1'b1;
        step();
        bus.flush = 1'b0;
        check("fhalt_valid", {15'd0, bus.validOut}, 16'h0000);
        check("fhalt_instr", bus.instrOut, 16'h0800);
        bus.instrIn  = 16'h0B60;
        bus.nextPcIn = 16'h0046;
        step();
        check("fhalt_flag0", {15'd0, bus.haltOut}, 16'h0000);
        check("fhalt_cap",   bus.instrOut, 16'h0B60);
        step();
        check("fhalt_flag1", {15'd0, bus.haltOut}, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_if_id_stage
